// File: rtl/key_line_buffer.sv
// Collects decoded PS/2 key codes into an edit line and commits it to a
// display buffer on Enter; the display is read back through a registered port.
module key_line_buffer #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4,
    parameter logic [3:0]  BLANK = 4'hF
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          kb_break,
    input  logic [3:0]    kb_char,
    input  logic [AW-1:0] rd_addr,
    output logic [3:0]    rd_data,
    output logic [AW:0]   line_len,
    output logic [AW:0]   edit_len,
    output logic          line_done,
    output logic          overflow,
    output logic [7:0]    err_count
);

    localparam int unsigned LW = AW + 1;
    localparam logic [3:0] CODE_ERR   = 4'hB;
    localparam logic [3:0] CODE_ENTER = 4'hC;

    typedef enum logic [1:0] {IDLE, CAPTURE, DECODE} state_t;

    state_t     state;
    logic [2:0] brk_sync;
    logic       evt;
    logic [3:0] code_q;
    logic [3:0] edit    [DEPTH];
    logic [3:0] display [DEPTH];

    // Two flops retime the strobe, the third gives the previous value for edge detection.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            brk_sync <= 3'b000;
        end else begin
            brk_sync <= {brk_sync[1:0], kb_break};
        end
    end

    assign evt = brk_sync[1] & ~brk_sync[2];

    // kb_char is quasi-static by the time evt fires, so it is sampled directly.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            code_q    <= 4'h0;
            edit_len  <= '0;
            line_len  <= '0;
            line_done <= 1'b0;
            overflow  <= 1'b0;
            err_count <= 8'h00;
            for (int i = 0; i < DEPTH; i++) begin
                edit[i]    <= BLANK;
                display[i] <= BLANK;
            end
        end else begin
            line_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (evt) begin
                        code_q <= kb_char;
                        state  <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    state <= DECODE;
                end
                DECODE: begin
                    state <= IDLE;
                    if (code_q <= 4'd9) begin
                        if (edit_len < LW'(DEPTH)) begin
                            edit[edit_len[AW-1:0]] <= code_q;
                            edit_len               <= edit_len + 1'b1;
                        end else begin
                            overflow <= 1'b1;
                        end
                    end else if (code_q == CODE_ENTER) begin
                        for (int i = 0; i < DEPTH; i++) begin
                            display[i] <= (LW'(i) < edit_len) ? edit[i] : BLANK;
                            edit[i]    <= BLANK;
                        end
                        line_len  <= edit_len;
                        edit_len  <= '0;
                        overflow  <= 1'b0;
                        line_done <= 1'b1;
                    end else if (code_q == CODE_ERR) begin
                        if (err_count != 8'hFF) begin
                            err_count <= err_count + 8'd1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Registered read; sees display contents as they stood before any same-cycle commit.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_data <= BLANK;
        end else begin
            rd_data <= ({1'b0, rd_addr} < line_len) ? display[rd_addr] : BLANK;
        end
    end

endmodule

// File: tb/tb_key_line_buffer.sv
// Randomized bench for key_line_buffer against a queue-based model of the edit
// line, display contents, overflow flag and error counter.
module tb_key_line_buffer;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = 4;

    logic          clock;
    logic          reset_n;
    logic          kb_break;
    logic [3:0]    kb_char;
    logic [AW-1:0] rd_addr;
    logic [3:0]    rd_data;
    logic [AW:0]   line_len;
    logic [AW:0]   edit_len;
    logic          line_done;
    logic          overflow;
    logic [7:0]    err_count;

    key_line_buffer #(.DEPTH(DEPTH), .AW(AW), .BLANK(4'hF)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .kb_break (kb_break),
        .kb_char  (kb_char),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .line_len (line_len),
        .edit_len (edit_len),
        .line_done(line_done),
        .overflow (overflow),
        .err_count(err_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    // reference model
    int m_edit[$];
    int m_disp[DEPTH];
    int m_line_len;
    int m_ovf;
    int m_err;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    function automatic void model_reset();
        m_edit.delete();
        for (int i = 0; i < DEPTH; i++) m_disp[i] = 15;
        m_line_len = 0;
        m_ovf      = 0;
        m_err      = 0;
    endfunction

    // returns the expected number of line_done pulses for this key
    function automatic int model_key(input int c);
        if (c <= 9) begin
            if (m_edit.size() < DEPTH) m_edit.push_back(c);
            else m_ovf = 1;
        end else if (c == 12) begin
            for (int i = 0; i < DEPTH; i++) m_disp[i] = (i < m_edit.size()) ? m_edit[i] : 15;
            m_line_len = m_edit.size();
            m_edit.delete();
            m_ovf = 0;
            return 1;
        end else if (c == 11) begin
            if (m_err < 255) m_err++;
        end
        return 0;
    endfunction

    task automatic check_state(input string tag);
        check({tag, ".edit_len"}, int'(edit_len), m_edit.size());
        check({tag, ".line_len"}, int'(line_len), m_line_len);
        check({tag, ".overflow"}, int'(overflow), m_ovf);
        check({tag, ".err_count"}, int'(err_count), m_err);
    endtask

    task automatic send_key(input int c, input bit full_check);
        int pulses = 0;
        int exp_pulses;
        @(negedge clock);
        kb_char  = 4'(c);
        kb_break = 1'b1;
        repeat (6) begin
            @(negedge clock);
            if (line_done) pulses++;
        end
        kb_break = 1'b0;
        repeat (4) begin
            @(negedge clock);
            if (line_done) pulses++;
        end
        exp_pulses = model_key(c);
        if (full_check) begin
            check("line_done", pulses, exp_pulses);
            check_state("key");
        end
    endtask

    task automatic check_reads(input string tag);
        for (int a = 0; a < DEPTH; a++) begin
            @(negedge clock);
            rd_addr = AW'(a);
            @(negedge clock);
            check({tag, ".rd_data"}, int'(rd_data), (a < m_line_len) ? m_disp[a] : 15);
        end
    endtask

    task automatic do_reset();
        #2 reset_n = 1'b0;
        kb_break = 1'b0;
        #13 reset_n = 1'b1;
        model_reset();
    endtask

    initial begin
        reset_n  = 1'b0;
        kb_break = 1'b0;
        kb_char  = 4'h0;
        rd_addr  = '0;
        model_reset();
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);

        check("reset.line_done", int'(line_done), 0);
        check("reset.rd_data0", int'(rd_data), 15);
        check_state("reset");
        check_reads("reset");

        // short line 1,2,3
        send_key(1, 1); send_key(2, 1); send_key(3, 1); send_key(12, 1);
        check_reads("line123");

        // overflow: 17 digits into a 16-slot line
        for (int i = 0; i < 17; i++) send_key(5, i >= 15);
        send_key(12, 1);
        check_reads("full");

        // error-code saturation
        for (int i = 0; i < 260; i++) send_key(11, i >= 250);
        send_key(7, 1);
        send_key(11, 1);

        // committed "42" followed by an empty line
        send_key(12, 1);
        send_key(4, 1); send_key(2, 1); send_key(12, 1);
        check_reads("line42");
        send_key(12, 1);
        check_reads("empty");

        // reset shortly after a strobe rise: the key must be lost
        @(negedge clock);
        kb_char  = 4'h9;
        kb_break = 1'b1;
        @(negedge clock);
        @(negedge clock);
        reset_n  = 1'b0;
        kb_break = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        model_reset();
        repeat (8) @(negedge clock);
        check_state("midreset");
        send_key(3, 1);
        check_reads("after_reset");

        // randomized traffic, digit-heavy so lines fill and overflow
        for (int i = 0; i < 400; i++) begin
            int r = int'($urandom_range(0, 19));
            int c = (r < 13) ? (r % 10) : (r < 16) ? 12 : (r < 18) ? 11 : int'($urandom_range(10, 15));
            send_key(c, 1);
            if (c == 12 && $urandom_range(0, 2) == 0) check_reads("rand");
        end

        do_reset();
        repeat (2) @(negedge clock);
        check_state("final_reset");
        check_reads("final_reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/key_line_buffer.md
Name: key_line_buffer

Overview:
- Sits directly downstream of the PS/2 keyboard decoder and consumes its 4-bit key code each time a key is released.
- Assembles digit keys into an edit line; Enter commits that line to a display buffer.
- The display buffer is read by the text renderer through a registered read port.
- Re-times the keyboard-domain outputs into the system clock domain.

Parameters:
- DEPTH, 16, number of character slots per line (power of two, 4..32).
- AW, 4, address width, equals log2(DEPTH).
- BLANK, 4'hF, code returned for unused display slots.

Ports:
- clock  in  1  system clock (all logic rising-edge).
- reset_n  in  1  asynchronous, active-low reset.
- kb_break  in  1  decoder frame strobe (asynchronous to clock); its rising edge marks a new key code.
- kb_char  in  4  decoder key code (asynchronous); stable from kb_break rise for at least 50 us.
- rd_addr  in  AW  display read address.
- rd_data  out  4  display slot code; 1-cycle latency.
- line_len  out  AW+1  length of the committed line (0..DEPTH).
- edit_len  out  AW+1  characters currently in the edit line.
- line_done  out  1  one-cycle pulse when a line is committed.
- overflow  out  1  sticky; a digit was dropped because the edit line was full.
- err_count  out  8  saturating count of error codes (4'hB) received.

Behaviour:
- Reset (asynchronous, reset_n=0): every output and internal register is cleared.
  - Edit and display arrays are set to BLANK.
  - line_len=0, edit_len=0, rd_data=BLANK, line_done=0, overflow=0, err_count=0.
  - Synchronizer flops are cleared; state = IDLE.
- Synchronization: kb_break passes through a 2-flop synchronizer plus a third flop for edge detection.
  - A rise on the synchronized signal produces an internal evt pulse.
  - kb_char is captured into code_q on the cycle evt is high; it needs no synchronizer because it is quasi-static at that point.
- FSM states:
  - IDLE: evt -> CAPTURE.
  - CAPTURE: code_q registered -> DECODE.
  - DECODE: performs one action, then -> IDLE.
- An evt arriving while in CAPTURE or DECODE is impossible by input timing. If one occurs, it is ignored and no queueing is done.
- Action for code 0..9:
  - If edit_len < DEPTH: edit[edit_len] <= code; edit_len++.
  - Otherwise the code is dropped and overflow is set to 1.
- Action for code 4'hC (Enter), all in one cycle:
  - display[i] <= edit[i] for i < edit_len, and BLANK for all other i.
  - line_len <= edit_len.
  - Edit array <= BLANK; edit_len <= 0; overflow <= 0.
  - line_done is asserted on the following cycle, for exactly one cycle.
- Enter with edit_len=0 commits an empty line: line_len=0, display all BLANK, line_done still pulses.
- Action for code 4'hB: err_count++, saturating at 255. Edit line is unchanged.
- Action for codes 4'hA, 4'hD, 4'hE, 4'hF: ignored, no state change.
- Read port:
  - rd_data <= (rd_addr < line_len) ? display[rd_addr] : BLANK, registered.
  - The read is combinationally independent of a commit in progress. A read issued in the commit cycle returns the old display contents.
- Reset mid-operation: asynchronous clear takes effect immediately. A partial frame or a pending evt is discarded.
- edit_len and line_len are AW+1 bits wide, so that exactly DEPTH is representable. They do not wrap.

Test Plan:
- Reset, then hold: all outputs at their reset values; rd_data=4'hF for every rd_addr.
- Send codes 1,2,3 then Enter (4'hC) -> line_done pulses once; line_len=3; rd_addr 0..3 reads 1,2,3,F; edit_len=0.
- Send 17 digits (value 5) with DEPTH=16 -> edit_len=16, overflow=1; after Enter: line_len=16, overflow=0, all 16 slots read 5.
- Send 4'hB 260 times -> err_count=255, edit_len unchanged; interleave a digit 7 -> edit_len=1.
- Send Enter on an empty line after a committed line "42" -> line_len=0, all slots read F, line_done pulses.
- Assert reset_n=0 for 1 cycle, two cycles after a kb_break rise carrying code 9 -> no write occurs; edit_len=0, and the next key is accepted normally.
